// File: rtl/shift_sequencer_pkg.sv
// Shared op-code and FSM state definitions for the shift sequencer and its
// single-bit shifter.
package shift_sequencer_pkg;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LEFT = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Combinational single-bit shifter: pass, left, logical right or arithmetic
// right by exactly one position, selected by a 2-bit shift code.
module shifter
  import shift_sequencer_pkg::*;
#(
  parameter int k = 16
) (
  input  logic [k-1:0] d,
  input  logic [1:0]   code,
  output logic [k-1:0] y
);

  always_comb begin
    unique case (code)
      SH_PASS: y = d;
      SH_LEFT: y = {d[k-2:0], 1'b0};
      SH_LSR:  y = {1'b0, d[k-1:1]};
      default: y = {d[k-1], d[k-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift-by-N controller: steps the single-bit shifter once per
// clock and reports completion with a start/busy/done handshake.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int k     = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [k-1:0]     data_in,
  output logic             busy,
  output logic             done,
  output logic [k-1:0]     data_out,
  output logic             carry
);

  state_t           state, state_nxt;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [1:0]       shift_code;
  logic [k-1:0]     step_val;
  logic             accept;

  assign accept     = (state == ST_IDLE) && start;
  // Shifter only sees a real code while stepping, so its output is otherwise a plain pass.
  assign shift_code = (state == ST_SHIFT) ? op_q : SH_PASS;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

  shifter #(.k(k)) u_shifter (
    .d    (data_out),
    .code (shift_code),
    .y    (step_val)
  );

  // NOTE: next-state is assigned a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = (op == SH_PASS || amount == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt == AMT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= SH_PASS;
      data_out <= '0;
      carry    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_out <= data_in;
        carry    <= 1'b0;
        cnt      <= amount;
        op_q     <= op;
      end else if (state == ST_SHIFT) begin
        data_out <= step_val;
        carry    <= (op_q == SH_LEFT) ? data_out[k-1] : data_out[0];
        cnt      <= cnt - AMT_W'(1);
      end
    end
  end

endmodule
